mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-ported memory bus between the instruction-fetch path and the load/store path. It sits between the core and the bus interface, and serializes one access at a time: data accesses first, then fetch. It returns registered read data with one-cycle hit pulses, and exposes `busy` so the core can freeze the PC and pipeline while an access is in flight. A watchdog aborts accesses that are never acknowledged.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Must be 32; `sel` is 4 bits.
- `TIMEOUT`, 255: access cycles without ack before abort. A value of 0 disables the watchdog.

Ports (clock and reset first):
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `nRst`  in  1  asynchronous, active-low reset.
- `i_ren`  in  1  fetch request (level).
- `i_addr`  in  ADDR_W  fetch address.
- `i_rdata`  out  DATA_W  fetched instruction (registered).
- `i_hit`  out  1  fetch complete (one-cycle pulse).
- `d_ren`  in  1  load request (level).
- `d_wen`  in  1  store request (level).
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_sel`  in  4  byte enables.
- `d_rdata`  out  DATA_W  load data (registered).
- `d_hit`  out  1  data access complete (one-cycle pulse).
- `bus_ren`  out  1  bus read strobe.
- `bus_wen`  out  1  bus write strobe.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_sel`  out  4  bus byte enables.
- `bus_rdata`  in  DATA_W  bus read data; valid only when `bus_ack` = 1.
- `bus_ack`  in  1  bus completion (one cycle).
- `err`  out  1  the current hit is a timeout abort.
- `busy`  out  1  state ≠ IDLE.

## Operation
States and transitions:
- **IDLE** samples requests.
  - `d_wen` → DWR.
  - else `d_ren` → DRD.
  - else `i_ren` → IRD.
  - else stay in IDLE.
  - On the transition, latch into registers: address, `wdata`, `sel`, and the access type.
- **IRD**:
  - `bus_ren` = 1.
  - `bus_addr` = {latched `i_addr`[ADDR_W-1:2], 2'b00}.
  - `bus_sel` = 4'hF.
- **DRD**:
  - `bus_ren` = 1.
  - `bus_addr` = latched `d_addr`.
  - `bus_sel` = latched `d_sel`.
- **DWR**:
  - `bus_wen` = 1.
  - `bus_addr`, `bus_wdata` and `bus_sel` come from the latched values.
- **Leaving any access state:**
  - `bus_ack` = 1 → RESP. On reads, `bus_rdata` is captured into `i_rdata` or `d_rdata`.
  - Watchdog count reaches TIMEOUT → RESP with the error flag set. The read-data register for that requester is loaded with 0.
- **RESP**:
  - Exactly one of `i_hit` or `d_hit` is 1 for this cycle.
  - `err` = the error flag.
  - Next state is IDLE unconditionally.

Rules:
- Bus strobes are decoded combinationally from the state. They are held stable, with latched address and data, until ack or abort. Strobes are 0 in IDLE and RESP.
- `i_rdata` and `d_rdata` hold their value until their next capture. Stores leave `d_rdata` unchanged.
- Watchdog counter: cleared on entry to an access state; +1 per access cycle with `bus_ack` = 0; saturates.
- `d_ren` and `d_wen` both high: treated as a store; no error.
- Requesters hold requests until their hit. A request still high in the cycle after its hit is a new request.
- Input changes during an access are ignored, because the latched copies are used.
- Data priority is strict. Fetch can be starved only by continuous data requests; the core never issues those.

## Timing
- All outputs are 0 in reset. The state goes to IDLE and the counter to 0 immediately on `nRst` low, including mid-access: strobes drop without waiting for ack, and a late ack after reset is ignored.
- Minimum latency: request sampled at edge E0 → strobe during cycle 0→1 → ack in that cycle → hit in cycle 1→2 → IDLE in cycle 2→3. That is 2 cycles from sample to hit, and 3 cycles per back-to-back access.
- Simultaneous fetch and data request: the data access completes first. Fetch is sampled in the IDLE cycle after the `d_hit` cycle.
- Ack arriving in the same cycle as the timeout: the ack wins and `err` = 0.
- `err` is only ever 1 together with a hit.

## Structure
- `cpu_pkg` gains `arb_state_t` (IDLE, IRD, DRD, DWR, RESP) and an `arb_src_t` enum. The package already has the CPU-wide constants.
- The watchdog counter is a natural sub-module, `arb_watchdog`, with inputs clear, count-enable and TIMEOUT, and an output expired. Everything else stays in one FSM.

## Test plan
- **Fetch only:** `i_ren` = 1, `i_addr` = 0x0000_1006, ack after 2 cycles with `bus_rdata` = 0x0051_0093. Expect `bus_addr` = 0x0000_1004, `bus_sel` = F, `i_hit` one cycle later, `i_rdata` = 0x0051_0093, `err` = 0.
- **Contention:** `i_ren` and `d_ren` both 1. Expect the DRD access first with `d_hit`, then the IRD access; `busy` high throughout except for one IDLE cycle between them.
- **Store:** `d_wen` = 1, `d_addr` = 0x2000, `d_wdata` = 0xDEADBEEF, `d_sel` = 4'b0011. Expect the bus to show exactly those values until ack, then `d_hit`, with `d_rdata` unchanged.
- **Timeout:** TIMEOUT = 4, no ack. Expect RESP after 4 access cycles with `d_hit` = 1, `err` = 1, `d_rdata` = 0. Also ack on the 4th cycle → `err` = 0.
- **Reset mid-access:** `nRst` low during DRD. Expect all outputs 0 immediately; an ack arriving later produces no hit.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : CPU-wide constants plus memory-arbiter state and source types
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int         c_word_w  = 32;
    localparam int         c_sel_w   = 4;
    localparam logic [3:0] c_sel_all = 4'hF;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_IRD  = 3'd1,
        ARB_DRD  = 3'd2,
        ARB_DWR  = 3'd3,
        ARB_RESP = 3'd4
    } arb_state_t;

    typedef enum logic {
        SRC_IFETCH = 1'b0,
        SRC_DATA   = 1'b1
    } arb_src_t;

    function automatic logic is_access(input arb_state_t s);
        return (s == ARB_IRD) || (s == ARB_DRD) || (s == ARB_DWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_watchdog.sv
// ============================================================================
// arb_watchdog : saturating no-ack cycle counter, flags the expiring cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int                 c_cnt_w  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic               c_enable = (TIMEOUT != 0);
    localparam logic [c_cnt_w-1:0] c_sat    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != c_sat)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose increment would make the count reach TIMEOUT.
    assign expired_o = c_enable && en_i && (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : serializes data and fetch accesses onto one memory bus,
//               data first, with registered read data and a timeout abort
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_hit,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_hit,
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              err,
    output logic              busy
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_src_t          src_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        sel_q;
    logic              err_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic w_access;
    logic w_expired;
    logic w_done;
    logic w_start;
    logic w_data_req;

    assign w_access   = is_access(state_q);
    assign w_done     = w_access && (bus_ack || w_expired);
    assign w_start    = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);
    assign w_data_req = d_wen || d_ren;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (nRst),
        .clr_i     (!w_access),
        .en_i      (w_access && !bus_ack),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (d_wen) begin
                    state_d = ARB_DWR;
                end else if (d_ren) begin
                    state_d = ARB_DRD;
                end else if (i_ren) begin
                    state_d = ARB_IRD;
                end
            end
            ARB_IRD, ARB_DRD, ARB_DWR: begin
                if (bus_ack || w_expired) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Request fields are frozen at the IDLE exit so the bus stays stable.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            src_q     <= SRC_IFETCH;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (w_start) begin
                src_q   <= w_data_req ? SRC_DATA : SRC_IFETCH;
                addr_q  <= w_data_req ? d_addr : i_addr;
                wdata_q <= d_wdata;
                sel_q   <= d_sel;
            end
            if (w_done) begin
                err_q <= !bus_ack;
                if (state_q == ARB_IRD) begin
                    i_rdata_q <= bus_ack ? bus_rdata : '0;
                end
                if (state_q == ARB_DRD) begin
                    d_rdata_q <= bus_ack ? bus_rdata : '0;
                end
            end
        end
    end

    always_comb begin
        bus_ren   = 1'b0;
        bus_wen   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_sel   = '0;
        i_hit     = 1'b0;
        d_hit     = 1'b0;
        err       = 1'b0;
        case (state_q)
            ARB_IRD: begin
                bus_ren  = 1'b1;
                bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
                bus_sel  = c_sel_all;
            end
            ARB_DRD: begin
                bus_ren  = 1'b1;
                bus_addr = addr_q;
                bus_sel  = sel_q;
            end
            ARB_DWR: begin
                bus_wen   = 1'b1;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                bus_sel   = sel_q;
            end
            ARB_RESP: begin
                i_hit = (src_q == SRC_IFETCH);
                d_hit = (src_q == SRC_DATA);
                err   = err_q;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != ARB_IDLE);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed vector table plus reset and back-to-back sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        nRst;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_hit;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        d_hit;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .i_ren     (i_ren),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_hit     (i_hit),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_sel     (d_sel),
        .d_rdata   (d_rdata),
        .d_hit     (d_hit),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  ds;
        logic        ack;
        logic [31:0] brd;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        logic        e_ihit;
        logic        e_dhit;
        logic        e_err;
        logic        e_busy;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] ds,
        input logic ack, input logic [31:0] brd,
        input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic [3:0] e_sel,
        input logic e_ihit, input logic e_dhit, input logic e_err, input logic e_busy,
        input logic [31:0] e_ird, input logic [31:0] e_drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ds = ds;
        v.ack = ack; v.brd = brd;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_sel = e_sel; v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_err = e_err;
        v.e_busy = e_busy; v.e_ird = e_ird; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0;
        d_wdata = 0; d_sel = 0; bus_ack = 0; bus_rdata = 0;
    endtask

    function automatic logic any_out();
        return |{bus_ren, bus_wen, bus_addr, bus_wdata, bus_sel,
                 i_hit, d_hit, err, busy, i_rdata, d_rdata};
    endfunction

    localparam logic [31:0] IR1 = 32'h0051_0093;
    localparam logic [31:0] IR2 = 32'h1234_5678;
    localparam logic [31:0] DR1 = 32'hCAFE_F00D;
    localparam logic [31:0] DR2 = 32'hA5A5_A5A5;

    initial begin
        int hits;
        int dhits;
        int first_hit;

        nRst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero", {31'b0, any_out()}, 32'h0);
        nRst = 1'b1;

        // Fetch only: misaligned address, ack on the second strobe cycle.
        vecs.push_back(V(1,32'h1006,0,0,0,0,0,0,0,       1,0,32'h1004,0,4'hF, 0,0,0,1, 0,0));
        vecs.push_back(V(1,32'h1006,0,0,0,0,0,0,0,       1,0,32'h1004,0,4'hF, 0,0,0,1, 0,0));
        vecs.push_back(V(1,32'h1006,0,0,0,0,0,1,IR1,     0,0,0,0,0,           1,0,0,1, IR1,0));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,           0,0,0,0, IR1,0));
        // Contention: load wins, one IDLE cycle, then the fetch.
        vecs.push_back(V(1,32'h43,1,0,32'h104,0,4'hF,0,0, 1,0,32'h104,0,4'hF, 0,0,0,1, IR1,0));
        vecs.push_back(V(1,32'h43,1,0,32'h104,0,4'hF,1,DR1, 0,0,0,0,0,        0,1,0,1, IR1,DR1));
        vecs.push_back(V(1,32'h43,0,0,0,0,0,0,0,          0,0,0,0,0,          0,0,0,0, IR1,DR1));
        vecs.push_back(V(1,32'h43,0,0,0,0,0,0,0,          1,0,32'h40,0,4'hF,  0,0,0,1, IR1,DR1));
        vecs.push_back(V(1,32'h43,0,0,0,0,0,1,IR2,        0,0,0,0,0,          1,0,0,1, IR2,DR1));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,               0,0,0,0,0,          0,0,0,0, IR2,DR1));
        // Store: inputs change mid-access, bus keeps latched values.
        vecs.push_back(V(0,0,0,1,32'h2000,32'hDEADBEEF,4'h3,0,0, 0,1,32'h2000,32'hDEADBEEF,4'h3, 0,0,0,1, IR2,DR1));
        vecs.push_back(V(0,0,0,1,32'h3000,32'h11111111,4'hF,0,0, 0,1,32'h2000,32'hDEADBEEF,4'h3, 0,0,0,1, IR2,DR1));
        vecs.push_back(V(0,0,0,1,32'h3000,32'h11111111,4'hF,1,32'hFFFFFFFF, 0,0,0,0,0, 0,1,0,1, IR2,DR1));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,               0,0,0,0,0,          0,0,0,0, IR2,DR1));
        // Load and store together: a store, no error.
        vecs.push_back(V(0,0,1,1,32'h2004,32'h0BADF00D,4'hC,0,0, 0,1,32'h2004,32'h0BADF00D,4'hC, 0,0,0,1, IR2,DR1));
        vecs.push_back(V(0,0,1,1,32'h2004,32'h0BADF00D,4'hC,1,32'h77, 0,0,0,0,0, 0,1,0,1, IR2,DR1));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,               0,0,0,0,0,          0,0,0,0, IR2,DR1));
        // Timeout: four access cycles without ack.
        vecs.push_back(V(0,0,1,0,32'h500,0,4'hF,0,0,      1,0,32'h500,0,4'hF, 0,0,0,1, IR2,DR1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(V(0,0,1,0,32'h500,0,4'hF,0,0,  1,0,32'h500,0,4'hF, 0,0,0,1, IR2,DR1));
        vecs.push_back(V(0,0,1,0,32'h500,0,4'hF,0,0,      0,0,0,0,0,          0,1,1,1, IR2,0));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,               0,0,0,0,0,          0,0,0,0, IR2,0));
        // Ack in the expiring cycle: ack wins.
        vecs.push_back(V(0,0,1,0,32'h504,0,4'hF,0,0,      1,0,32'h504,0,4'hF, 0,0,0,1, IR2,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(V(0,0,1,0,32'h504,0,4'hF,0,0,  1,0,32'h504,0,4'hF, 0,0,0,1, IR2,0));
        vecs.push_back(V(0,0,1,0,32'h504,0,4'hF,1,DR2,    0,0,0,0,0,          0,1,0,1, IR2,DR2));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,               0,0,0,0,0,          0,0,0,0, IR2,DR2));

        for (int i = 0; i < vecs.size(); i++) begin
            i_ren = vecs[i].ir;   i_addr = vecs[i].ia;
            d_ren = vecs[i].dr;   d_wen = vecs[i].dw;   d_addr = vecs[i].da;
            d_wdata = vecs[i].dwd; d_sel = vecs[i].ds;
            bus_ack = vecs[i].ack; bus_rdata = vecs[i].brd;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.bus_ren", i),   {31'b0, bus_ren},  {31'b0, vecs[i].e_ren});
            check($sformatf("v%0d.bus_wen", i),   {31'b0, bus_wen},  {31'b0, vecs[i].e_wen});
            check($sformatf("v%0d.bus_addr", i),  bus_addr,          vecs[i].e_addr);
            check($sformatf("v%0d.bus_wdata", i), bus_wdata,         vecs[i].e_wdata);
            check($sformatf("v%0d.bus_sel", i),   {28'b0, bus_sel},  {28'b0, vecs[i].e_sel});
            check($sformatf("v%0d.i_hit", i),     {31'b0, i_hit},    {31'b0, vecs[i].e_ihit});
            check($sformatf("v%0d.d_hit", i),     {31'b0, d_hit},    {31'b0, vecs[i].e_dhit});
            check($sformatf("v%0d.err", i),       {31'b0, err},      {31'b0, vecs[i].e_err});
            check($sformatf("v%0d.busy", i),      {31'b0, busy},     {31'b0, vecs[i].e_busy});
            check($sformatf("v%0d.i_rdata", i),   i_rdata,           vecs[i].e_ird);
            check($sformatf("v%0d.d_rdata", i),   d_rdata,           vecs[i].e_drd);
        end

        // Back-to-back fetches with request and ack held high: hit every 3 cycles.
        idle_inputs();
        i_ren = 1; i_addr = 32'h80; bus_ack = 1; bus_rdata = 32'h77;
        hits = 0; dhits = 0; first_hit = -1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (i_hit) begin
                hits++;
                if (first_hit < 0) first_hit = k;
            end
            if (d_hit) dhits++;
        end
        check("b2b_hit_count", hits, 3);
        check("b2b_first_hit", first_hit, 1);
        check("b2b_no_dhit", dhits, 0);
        check("b2b_rdata", i_rdata, 32'h77);
        i_ren = 0;
        repeat (3) @(posedge clk);
        #1;
        bus_ack = 0;
        check("b2b_back_idle", {31'b0, busy}, 32'h0);

        // Reset in the middle of a load, then a late ack.
        d_ren = 1; d_addr = 32'h600; d_sel = 4'hF;
        @(posedge clk);
        #1;
        check("mid_rst_in_drd", {31'b0, bus_ren}, 32'h1);
        #2;
        nRst = 1'b0;
        #1;
        check("mid_rst_outputs_zero", {31'b0, any_out()}, 32'h0);
        d_ren = 0;
        @(posedge clk);
        #1;
        nRst = 1'b1;
        bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
        hits = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bus_ack = 0;
            if (i_hit || d_hit || busy) hits++;
        end
        check("late_ack_ignored", hits, 0);
        check("late_ack_drdata", d_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
